btn_conditioner: RTL
====================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive cycles of stable synchronized level required to accept a change (>=1).
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the number of HELD cycles before the first auto-repeat pulse (>=1).
REQ-003 Parameter REPEAT_PERIOD, default 5000000, is the number of cycles between subsequent auto-repeat pulses (>=1).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 btn_raw  input  1  asynchronous mechanical button, active high.
REQ-007 repeat_en  input  1  enables auto-repeat while the button is held.
REQ-008 btn_level  output  1  debounced button level.
REQ-009 press_pulse  output  1  one-cycle pulse on accepted press.
REQ-010 release_pulse  output  1  one-cycle pulse on accepted release.
REQ-011 repeat_pulse  output  1  one-cycle auto-repeat pulse.
REQ-012 inc_pulse  output  1  press_pulse OR repeat_pulse; drives the digit-select counter's increment input.

Function
REQ-013 btn_raw SHALL pass through a 2-flop synchronizer; its output is btn_sync; no other logic SHALL sample btn_raw.
REQ-014 The FSM SHALL have states IDLE, PRESS_CHK, HELD and REL_CHK.
REQ-015 In IDLE, btn_sync=1 SHALL move the FSM to PRESS_CHK with deb_cnt=0.
REQ-016 In PRESS_CHK, btn_sync=0 SHALL return the FSM to IDLE, with no pulse and deb_cnt cleared.
REQ-017 In PRESS_CHK, btn_sync=1 with deb_cnt=DEBOUNCE_CYCLES-1 SHALL move the FSM to HELD, register btn_level=1 and press_pulse=1 for exactly one cycle; otherwise deb_cnt SHALL increment.
REQ-018 Press latency SHALL be exactly DEBOUNCE_CYCLES+2 rising edges after the edge that first samples btn_raw high, counted to the edge that registers press_pulse, provided btn_raw stays high.
REQ-019 In HELD, btn_sync=0 SHALL move the FSM to REL_CHK with deb_cnt=0; rep_cnt SHALL freeze.
REQ-020 In REL_CHK, btn_sync=1 SHALL return the FSM to HELD with rep_cnt unchanged and no pulse.
REQ-021 In REL_CHK, DEBOUNCE_CYCLES consecutive low cycles SHALL move the FSM to IDLE, register btn_level=0 and release_pulse=1 for one cycle; release latency mirrors REQ-018.
REQ-022 Auto-repeat: in HELD with repeat_en=1, rep_cnt SHALL count from 0 (cleared on HELD entry from PRESS_CHK).
REQ-023 repeat_pulse SHALL fire when rep_cnt reaches REPEAT_DELAY-1, then every REPEAT_PERIOD cycles while held.
REQ-024 repeat_en=0 SHALL clear rep_cnt and suppress repeat_pulse; re-assertion SHALL restart the full REPEAT_DELAY.
REQ-025 press_pulse and repeat_pulse SHALL never assert in the same cycle; at most one inc_pulse per cycle.
REQ-026 Counters SHALL saturate/clear, never wrap; widths SHALL be $clog2 of the relevant parameter plus 1.
REQ-027 All outputs except inc_pulse SHALL be registered; inc_pulse SHALL be a single OR gate.

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE, synchronizer flops 0, deb_cnt 0, rep_cnt 0, all outputs 0.
REQ-029 Reset asserted mid-press or mid-hold SHALL abort without any pulse; after release of reset, a still-held button SHALL be re-debounced from IDLE, yielding a fresh press_pulse.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, PRESS_CHK, HELD, REL_CHK) and the default parameter constants.
REQ-031 The synchronizer SHALL be a separate sub-module sync_2ff (clk, reset_n, d, q), reusable for mode_select and equals_switch.

Verification (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-032 Clean press: btn_raw high from edge 0 -> press_pulse registered at edge 6, one cycle, btn_level=1; release mirrors with release_pulse.
REQ-033 Bounce: btn_raw toggles high 2 cycles, low 1, then holds high -> exactly one press_pulse, no release_pulse.
REQ-034 Hold with repeat_en=1 for 30 cycles in HELD -> repeat_pulse at rep_cnt 9, 12, 15, ... (7 pulses); inc_pulse count = 8 including press.
REQ-035 Hold with repeat_en toggled 1->0->1 mid-hold -> no repeat while 0; first repeat 10 cycles after re-enable.
REQ-036 Release glitch: in HELD, btn_raw low 2 cycles then high -> no release_pulse, btn_level stays 1, repeat resumes from the frozen count.
REQ-037 reset_n pulsed low during PRESS_CHK and during HELD -> all outputs 0 asynchronously; a held button yields a new press_pulse DEBOUNCE_CYCLES+2 edges after reset release.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// Shared types and default timing constants for the push-button conditioner
// and its companion switch inputs.
package btn_conditioner_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_conditioner_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (button, mode
// select, equals switch).
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounced push-button with press/release pulses and hold-to-repeat,
// producing a single increment strobe for the digit-select counter.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic inc_pulse
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX) + 1;

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE     = DEB_W'(1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);

  btn_state_e       state;
  logic             btn_sync;
  logic [DEB_W-1:0] deb_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             rep_armed;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_raw),
    .q       (btn_sync)
  );

  // Debounce FSM: a level change is accepted only after the synchronized
  // input has held the new value for the full debounce window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_sync) begin
            state   <= PRESS_CHK;
            deb_cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (!btn_sync) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= HELD;
            deb_cnt     <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
          end
        end
        HELD: begin
          if (!btn_sync) begin
            state   <= REL_CHK;
            deb_cnt <= '0;
          end
        end
        REL_CHK: begin
          if (btn_sync) begin
            state   <= HELD;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          deb_cnt <= '0;
        end
      endcase
    end
  end

  // Auto-repeat: first target is the initial delay, then the period. The
  // count freezes during a release check so a short glitch resumes cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt      <= '0;
      rep_armed    <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (!repeat_en || !((state == HELD) || (state == REL_CHK))) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b0;
      end else if ((state == HELD) && btn_sync) begin
        if (rep_cnt == (rep_armed ? PERIOD_LAST : DELAY_LAST)) begin
          repeat_pulse <= 1'b1;
          rep_cnt      <= '0;
          rep_armed    <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + REP_ONE;
        end
      end
    end
  end

  assign inc_pulse = press_pulse | repeat_pulse;

endmodule
